// File: rtl/mmc_i2c_target_model.sv
// I2C target emulating the CMPS2 magnetometer (MMC34160PJ subset).
// Injected X/Y/Z fields are served through the device register map.
module mmc_i2c_target_model #(
    parameter logic [6:0] DEV_ADDR     = 7'h30,
    parameter logic [7:0] PRODUCT_ID   = 8'h06,
    parameter int         FILTER_LEN   = 3,
    parameter int         MEAS_LATENCY = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_oe,
    input  logic [15:0] mag_x,
    input  logic [15:0] mag_y,
    input  logic [15:0] mag_z,
    output logic [7:0]  ctrl0,
    output logic        meas_done,
    output logic        busy
);

    localparam int CW = (MEAS_LATENCY > 1) ? $clog2(MEAS_LATENCY) : 1;
    localparam logic [CW-1:0] M_END = CW'(MEAS_LATENCY - 1);
    localparam logic [2:0] F_END = 3'(FILTER_LEN - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_PTR, S_PTR_ACK,
        S_WR_DATA, S_DATA_ACK, S_RD_DATA, S_HOST_ACK, S_WAIT_STOP
    } state_t;

    state_t state, state_n;
    logic [1:0] scl_sync, sda_sync;
    logic [2:0] scl_cnt, sda_cnt;
    logic scl_f, sda_f, scl_q, sda_q;
    logic scl_rise, scl_fall, start_c, stop_c;
    logic [3:0] bcnt, bcnt_n;
    logic [7:0] shreg, shreg_n, ptr, ptr_n, rd_byte;
    logic oe_n, busy_n, rd_mode, rd_n, wr_en, release_c;
    logic status, meas_on, pend, meas_fin;
    logic [CW-1:0] mcnt;
    logic [15:0] dx, dy, dz, px, py, pz;

    // two-stage synchronizer followed by a consecutive-sample glitch filter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_f    <= 1'b1;
            sda_f    <= 1'b1;
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
            scl_cnt  <= 3'd0;
            sda_cnt  <= 3'd0;
        end else begin
            scl_sync <= {scl_sync[0], scl_in};
            sda_sync <= {sda_sync[0], sda_in};
            scl_q    <= scl_f;
            sda_q    <= sda_f;
            if (scl_sync[1] == scl_f) begin
                scl_cnt <= 3'd0;
            end else if (scl_cnt == F_END) begin
                scl_f   <= scl_sync[1];
                scl_cnt <= 3'd0;
            end else begin
                scl_cnt <= scl_cnt + 3'd1;
            end
            if (sda_sync[1] == sda_f) begin
                sda_cnt <= 3'd0;
            end else if (sda_cnt == F_END) begin
                sda_f   <= sda_sync[1];
                sda_cnt <= 3'd0;
            end else begin
                sda_cnt <= sda_cnt + 3'd1;
            end
        end
    end

    assign scl_rise = scl_f & ~scl_q;
    assign scl_fall = ~scl_f & scl_q;
    assign start_c  = scl_f & scl_q & sda_q & ~sda_f;
    assign stop_c   = scl_f & scl_q & ~sda_q & sda_f;
    assign meas_fin = meas_on && (mcnt == M_END);

    // register map read mux
    always_comb begin
        rd_byte = 8'h00;
        case (ptr)
            8'h00:   rd_byte = dx[7:0];
            8'h01:   rd_byte = dx[15:8];
            8'h02:   rd_byte = dy[7:0];
            8'h03:   rd_byte = dy[15:8];
            8'h04:   rd_byte = dz[7:0];
            8'h05:   rd_byte = dz[15:8];
            8'h06:   rd_byte = {7'd0, status};
            8'h07:   rd_byte = ctrl0;
            8'h20:   rd_byte = PRODUCT_ID;
            default: rd_byte = 8'h00;
        endcase
    end

    // protocol state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            bcnt    <= 4'd0;
            shreg   <= 8'd0;
            ptr     <= 8'd0;
            sda_oe  <= 1'b0;
            busy    <= 1'b0;
            rd_mode <= 1'b0;
        end else begin
            state   <= state_n;
            bcnt    <= bcnt_n;
            shreg   <= shreg_n;
            ptr     <= ptr_n;
            sda_oe  <= oe_n;
            busy    <= busy_n;
            rd_mode <= rd_n;
        end
    end

    // next state; SDA only moves on SCL fall, START/STOP override all
    always_comb begin
        state_n   = state;
        bcnt_n    = bcnt;
        shreg_n   = shreg;
        ptr_n     = ptr;
        oe_n      = sda_oe;
        busy_n    = busy;
        rd_n      = rd_mode;
        wr_en     = 1'b0;
        release_c = 1'b0;
        if (stop_c) begin
            state_n   = S_IDLE;
            oe_n      = 1'b0;
            busy_n    = 1'b0;
            rd_n      = 1'b0;
            release_c = 1'b1;
        end else if (start_c) begin
            state_n = S_ADDR;
            bcnt_n  = 4'd0;
            oe_n    = 1'b0;
            busy_n  = 1'b0;
        end else begin
            unique case (state)
                S_ADDR, S_WR_PTR, S_WR_DATA: begin
                    if (scl_rise && bcnt != 4'd8) begin
                        shreg_n = {shreg[6:0], sda_f};
                        bcnt_n  = bcnt + 4'd1;
                    end else if (scl_fall && bcnt == 4'd8) begin
                        bcnt_n = 4'd0;
                        if (state == S_ADDR) begin
                            if (shreg[7:1] == DEV_ADDR) begin
                                state_n = S_ADDR_ACK;
                                oe_n    = 1'b1;
                                busy_n  = 1'b1;
                                rd_n    = shreg[0];
                            end else begin
                                state_n   = S_WAIT_STOP;
                                rd_n      = 1'b0;
                                release_c = 1'b1;
                            end
                        end else if (state == S_WR_PTR) begin
                            state_n = S_PTR_ACK;
                            oe_n    = 1'b1;
                            ptr_n   = shreg;
                        end else begin
                            state_n = S_DATA_ACK;
                            oe_n    = 1'b1;
                            wr_en   = 1'b1;
                            ptr_n   = ptr + 8'd1;
                        end
                    end
                end
                S_ADDR_ACK: begin
                    if (scl_fall) begin
                        bcnt_n = 4'd0;
                        if (rd_mode) begin
                            state_n = S_RD_DATA;
                            shreg_n = rd_byte;
                            ptr_n   = ptr + 8'd1;
                            oe_n    = ~rd_byte[7];
                        end else begin
                            state_n = S_WR_PTR;
                            oe_n    = 1'b0;
                        end
                    end
                end
                S_PTR_ACK, S_DATA_ACK: begin
                    if (scl_fall) begin
                        state_n = S_WR_DATA;
                        bcnt_n  = 4'd0;
                        oe_n    = 1'b0;
                    end
                end
                S_RD_DATA: begin
                    if (scl_rise && bcnt != 4'd8) begin
                        bcnt_n = bcnt + 4'd1;
                    end else if (scl_fall) begin
                        if (bcnt == 4'd8) begin
                            state_n = S_HOST_ACK;
                            bcnt_n  = 4'd0;
                            oe_n    = 1'b0;
                        end else begin
                            shreg_n = {shreg[6:0], 1'b0};
                            oe_n    = ~shreg[6];
                        end
                    end
                end
                S_HOST_ACK: begin
                    if (scl_rise) begin
                        shreg_n = {shreg[6:0], sda_f};
                    end else if (scl_fall) begin
                        if (!shreg[0]) begin
                            state_n = S_RD_DATA;
                            shreg_n = rd_byte;
                            ptr_n   = ptr + 8'd1;
                            oe_n    = ~rd_byte[7];
                        end else begin
                            state_n = S_WAIT_STOP;
                            oe_n    = 1'b0;
                        end
                    end
                end
                S_IDLE, S_WAIT_STOP: ;
                default: state_n = S_IDLE;
            endcase
        end
    end

    // ctrl0 writes, measurement timer and coherent data register update
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl0     <= 8'd0;
            status    <= 1'b0;
            meas_on   <= 1'b0;
            mcnt      <= '0;
            meas_done <= 1'b0;
            pend      <= 1'b0;
            dx        <= 16'h8000;
            dy        <= 16'h8000;
            dz        <= 16'h8000;
            px        <= 16'h8000;
            py        <= 16'h8000;
            pz        <= 16'h8000;
        end else begin
            meas_done <= 1'b0;
            if (release_c && pend) begin
                dx   <= px;
                dy   <= py;
                dz   <= pz;
                pend <= 1'b0;
            end
            if (wr_en && ptr == 8'h07) begin
                ctrl0 <= shreg;
                if (shreg[0]) begin
                    status  <= 1'b0;
                    meas_on <= 1'b1;
                    mcnt    <= '0;
                end
            end else if (meas_fin) begin
                meas_on   <= 1'b0;
                ctrl0[0]  <= 1'b0;
                status    <= 1'b1;
                meas_done <= 1'b1;
                if (busy && rd_mode && !release_c) begin
                    pend <= 1'b1;
                    px   <= mag_x + 16'h8000;
                    py   <= mag_y + 16'h8000;
                    pz   <= mag_z + 16'h8000;
                end else begin
                    pend <= 1'b0;
                    dx   <= mag_x + 16'h8000;
                    dy   <= mag_y + 16'h8000;
                    dz   <= mag_z + 16'h8000;
                end
            end else if (meas_on) begin
                mcnt <= mcnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mmc_i2c_target_model.sv
// Bench for mmc_i2c_target_model: bit-banged I2C host, register-map
// reference model and an expectation/observation scoreboard.
module tb_mmc_i2c_target_model;

    localparam int LAT = 1500;
    localparam int H   = 20;
    localparam int Q   = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        scl_drv = 1'b1;
    logic        sda_low = 1'b0;
    logic        sda_bus;
    logic        sda_oe, meas_done, busy;
    logic [7:0]  ctrl0;
    logic [15:0] mag_x = '0, mag_y = '0, mag_z = '0;

    assign sda_bus = ~(sda_low | sda_oe);

    mmc_i2c_target_model #(.MEAS_LATENCY(LAT)) dut (
        .clk(clk), .reset(reset), .scl_in(scl_drv), .sda_in(sda_bus),
        .sda_oe(sda_oe), .mag_x(mag_x), .mag_y(mag_y), .mag_z(mag_z),
        .ctrl0(ctrl0), .meas_done(meas_done), .busy(busy)
    );

    always #5 clk = ~clk;

    // event counters watched between clock edges
    int md_cnt = 0, md_busy_cnt = 0, oe_hit_cnt = 0;
    bit oe_watch = 1'b0;
    always @(negedge clk) if (meas_done) md_cnt <= md_cnt + 1;
    always @(negedge clk) if (meas_done && busy) md_busy_cnt <= md_busy_cnt + 1;
    always @(negedge clk) if (oe_watch && sda_oe) oe_hit_cnt <= oe_hit_cnt + 1;

    // scoreboard
    int    exp_v[$];
    string exp_n[$];
    int    obs_v[$];
    string obs_n[$];
    int    n_cmp = 0, n_bad = 0;

    task automatic expect_v(input string n, input int v);
        exp_n.push_back(n);
        exp_v.push_back(v);
    endtask

    task automatic post(input string n, input int v);
        obs_n.push_back(n);
        obs_v.push_back(v);
    endtask

    task automatic check(input string n, input int e, input int a);
        expect_v(n, e);
        post(n, a);
    endtask

    // monitor: pops each observation and compares with the oldest expectation
    initial forever begin
        @(negedge clk);
        while (obs_v.size() > 0) begin
            string on, en;
            int    ov, ev;
            on = obs_n.pop_front();
            ov = obs_v.pop_front();
            n_cmp++;
            if (exp_v.size() == 0) begin
                n_bad++;
                $display("FAIL %s: got %0h, nothing expected", on, ov);
            end else begin
                en = exp_n.pop_front();
                ev = exp_v.pop_front();
                if (en != on || ev != ov) begin
                    n_bad++;
                    $display("FAIL %s: got %0h required %0h (%s)", on, ov, ev, en);
                end
            end
        end
    end

    // reference model of the register map
    logic [15:0] mx, my, mz;
    logic [7:0]  st_m, c0_m, ptr_m;

    function automatic logic [7:0] mbyte(input logic [7:0] a);
        logic [15:0] xo, yo, zo;
        xo = mx + 16'd32768;
        yo = my + 16'd32768;
        zo = mz + 16'd32768;
        case (a)
            8'h00:   return xo[7:0];
            8'h01:   return xo[15:8];
            8'h02:   return yo[7:0];
            8'h03:   return yo[15:8];
            8'h04:   return zo[7:0];
            8'h05:   return zo[15:8];
            8'h06:   return st_m;
            8'h07:   return c0_m;
            8'h20:   return 8'h06;
            default: return 8'h00;
        endcase
    endfunction

    task automatic mwrite(input logic [7:0] d);
        if (ptr_m == 8'h07) begin
            c0_m = d;
            if (d[0]) st_m = 8'h00;
        end
        ptr_m = ptr_m + 8'd1;
    endtask

    task automatic mcommit();
        mx = mag_x;
        my = mag_y;
        mz = mag_z;
        st_m = 8'h01;
        c0_m[0] = 1'b0;
    endtask

    task automatic mreset();
        mx = '0; my = '0; mz = '0;
        st_m = 8'h00; c0_m = 8'h00; ptr_m = 8'h00;
    endtask

    // bus host
    task automatic clks(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic send_bit(input bit b, input bit g);
        clks(Q);
        sda_low = ~b;
        if (g) begin
            clks(3);
            scl_drv = 1'b1;
            clks(1);
            scl_drv = 1'b0;
            clks(Q - 4);
        end else begin
            clks(Q);
        end
        scl_drv = 1'b1;
        clks(H);
        scl_drv = 1'b0;
    endtask

    task automatic recv_bit(output bit b);
        clks(Q);
        sda_low = 1'b0;
        clks(Q);
        scl_drv = 1'b1;
        clks(Q);
        #1 b = sda_bus;
        clks(Q);
        scl_drv = 1'b0;
    endtask

    task automatic h_start();
        clks(Q);
        sda_low = 1'b0;
        clks(Q);
        scl_drv = 1'b1;
        clks(H);
        sda_low = 1'b1;
        clks(H);
        scl_drv = 1'b0;
    endtask

    task automatic h_stop();
        clks(Q);
        sda_low = 1'b1;
        clks(Q);
        scl_drv = 1'b1;
        clks(H);
        sda_low = 1'b0;
        clks(H);
    endtask

    task automatic wbyte(input logic [7:0] b, input bit ack_e, input bit g);
        bit a;
        expect_v("ack", ack_e);
        for (int i = 7; i >= 0; i--) send_bit(b[i], g && i == 3);
        recv_bit(a);
        post("ack", !a);
    endtask

    task automatic rbyte(input bit nack, input string nm);
        logic [7:0] v;
        bit x;
        expect_v(nm, mbyte(ptr_m));
        ptr_m = ptr_m + 8'd1;
        v = '0;
        for (int i = 0; i < 8; i++) begin
            recv_bit(x);
            v = {v[6:0], x};
        end
        send_bit(nack, 1'b0);
        post(nm, v);
    endtask

    task automatic set_ptr(input logic [7:0] p);
        h_start();
        wbyte(8'h60, 1'b1, 1'b0);
        wbyte(p, 1'b1, 1'b0);
        ptr_m = p;
    endtask

    task automatic rd(input int n, input string nm);
        h_start();
        wbyte(8'h61, 1'b1, 1'b0);
        for (int i = 0; i < n; i++) rbyte(i == n - 1, nm);
    endtask

    task automatic wr_reg(input logic [7:0] p, input logic [7:0] d);
        set_ptr(p);
        wbyte(d, 1'b1, 1'b0);
        mwrite(d);
        h_stop();
    endtask

    task automatic wait_md(input int base);
        int k;
        k = 0;
        while (md_cnt == base && k < 2 * LAT) begin
            clks(1);
            k++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int base, bb, r;
        logic [7:0] p, d;
        mreset();
        clks(5);
        @(negedge clk);
        reset = 1'b0;
        clks(2);
        @(negedge clk);
        check("rst_sda_oe", 0, sda_oe);
        check("rst_busy", 0, busy);
        check("rst_ctrl0", 0, ctrl0);
        check("rst_meas_done", 0, meas_done);

        // trigger a measurement and poll status
        mag_x = 16'd100;
        mag_y = -16'sd200;
        mag_z = 16'd0;
        base = md_cnt;
        wr_reg(8'h07, 8'h01);
        wait_md(base);
        mcommit();
        clks(20);
        @(negedge clk);
        check("meas_pulses", base + 1, md_cnt);
        check("ctrl0_selfclr", c0_m, ctrl0);
        set_ptr(8'h06);
        rd(1, "status");
        h_stop();

        // six-byte data burst
        set_ptr(8'h00);
        rd(6, "burst");
        @(negedge clk);
        check("busy_in_read", 1, busy);
        h_stop();
        clks(10);
        @(negedge clk);
        check("busy_after_stop", 0, busy);

        // foreign address is never acknowledged
        base = oe_hit_cnt;
        oe_watch = 1'b1;
        h_start();
        wbyte(8'h62, 1'b0, 1'b0);
        wbyte(8'h5A, 1'b0, 1'b0);
        h_stop();
        clks(10);
        oe_watch = 1'b0;
        @(negedge clk);
        check("foreign_oe", base, oe_hit_cnt);
        check("foreign_busy", 0, busy);

        // product id and pointer wrap
        set_ptr(8'h20);
        rd(1, "prod_id");
        h_stop();
        set_ptr(8'hFF);
        rd(2, "wrap");
        h_stop();

        // measurement completes inside a burst
        mag_x = 16'($urandom);
        mag_y = 16'($urandom);
        mag_z = 16'($urandom);
        base = md_cnt;
        bb = md_busy_cnt;
        set_ptr(8'h07);
        wbyte(8'h01, 1'b1, 1'b0);
        mwrite(8'h01);
        set_ptr(8'h00);
        rd(6, "coherent");
        h_stop();
        clks(10);
        @(negedge clk);
        check("meas_in_burst", base + 1, md_cnt);
        check("meas_while_busy", bb + 1, md_busy_cnt);
        mcommit();
        set_ptr(8'h00);
        rd(7, "new_data");
        h_stop();

        // randomized register traffic
        for (int it = 0; it < 8; it++) begin
            r = $urandom_range(0, 2);
            if (r == 0) begin
                d = 8'($urandom) & 8'hFE;
                wr_reg(8'h07, d);
                set_ptr(8'h07);
                rd(1, "ctrl0_rb");
                h_stop();
                @(negedge clk);
                check("ctrl0_port", c0_m, ctrl0);
            end else if (r == 1) begin
                r = $urandom_range(0, 9);
                p = (r == 8) ? 8'h20 : (r == 9) ? 8'($urandom) : 8'(r);
                set_ptr(p);
                rd(2, "rand_rd");
                h_stop();
            end else begin
                do p = 8'($urandom); while (p == 8'h07);
                d = 8'($urandom);
                wr_reg(p, d);
                set_ptr(p);
                rd(1, "ro_rd");
                h_stop();
            end
        end

        // SCL glitch while writing ctrl0
        set_ptr(8'h07);
        wbyte(8'h5A, 1'b1, 1'b1);
        mwrite(8'h5A);
        h_stop();
        set_ptr(8'h07);
        rd(1, "glitch_rb");
        h_stop();

        // reset while the target drives ACK
        h_start();
        for (int i = 7; i >= 0; i--) send_bit(bit'(8'h60 >> i), 1'b0);
        clks(Q);
        sda_low = 1'b0;
        clks(Q);
        scl_drv = 1'b1;
        clks(Q);
        @(negedge clk);
        check("ack_drive", 1, sda_oe);
        reset = 1'b1;
        #1;
        check("rst_oe_async", 0, sda_oe);
        clks(3);
        @(negedge clk);
        reset = 1'b0;
        mreset();
        clks(Q);
        scl_drv = 1'b0;
        h_stop();
        clks(10);
        @(negedge clk);
        check("post_rst_busy", 0, busy);
        check("post_rst_ctrl0", 0, ctrl0);
        rd(8, "post_rst");
        h_stop();

        clks(20);
        if (exp_v.size() != 0) begin
            n_bad += exp_v.size();
            $display("FAIL drain: %0d expectations unmatched, required 0", exp_v.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
